// File: rtl/seg7_pkg.sv
// Shared mode encoding, segment glyphs ({g,f,e,d,c,b,a}, active-low) and the prime-choice table.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_BLANK    = 2'd0,
        MODE_READY    = 2'd1,
        MODE_QUESTION = 2'd2,
        MODE_INPUT    = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_READY = 7'b1111011;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1011000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Last decimal digit of the k-th prime (2,3,5,7,11,13,17,19,23) for k = 1..9.
    function automatic logic [3:0] prime_last(input logic [3:0] k);
        logic [3:0] p;
        case (k)
            4'd1:    p = 4'd2;
            4'd2:    p = 4'd3;
            4'd3:    p = 4'd5;
            4'd4:    p = 4'd7;
            4'd5:    p = 4'd1;
            4'd6:    p = 4'd3;
            4'd7:    p = 4'd7;
            4'd8:    p = 4'd9;
            4'd9:    p = 4'd3;
            default: p = 4'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational per-digit renderer: (mode, code, blank_force) -> active-low segments.
module seg7_glyph
    import seg7_pkg::*;
(
    input  mode_e      mode,
    input  logic [3:0] code,
    input  logic       blank_force,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank_force) begin
            case (mode)
                MODE_READY:    seg = SEG_READY;
                MODE_QUESTION: seg = digit_glyph(code);
                MODE_INPUT: begin
                    if (code == 4'd0)
                        seg = SEG_DASH;
                    else if (code <= 4'd9)
                        seg = digit_glyph(prime_last(code));
                end
                default:       seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_multi_disp.sv
// N-digit registered 7-seg controller: code register file, cursor blink, registered nHEX.
// Optional leading-zero blanking in QUESTION mode under SEG7_ZERO_BLANK_EN.
module seg7_multi_disp
    import seg7_pkg::*;
#(
    parameter int NDIG       = 6,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [1:0]                              MODE,
    input  logic                                    WE,
    input  logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] WADDR,
    input  logic [3:0]                              WDATA,
    input  logic                                    CLR,
    input  logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] CUR,
    output logic [7*NDIG-1:0]                       nHEX
);

    localparam int AW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(BLINK_HALF);

    logic [3:0]       codes [NDIG];
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             phase, phase_nxt;
    logic [1:0]       mode_q;
    logic [AW-1:0]    cur_q;
    logic             chg, in_input;
    logic [NDIG-1:0]  zero_sup;
    logic [7*NDIG-1:0] seg_all;
    mode_e            mode;

    assign mode     = mode_e'(MODE);
    assign in_input = (mode == MODE_INPUT);
    assign chg      = (MODE != mode_q) || (CUR != cur_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NDIG; i++) codes[i] <= 4'hF;
        end else if (CLR) begin
            for (int i = 0; i < NDIG; i++) codes[i] <= 4'h0;
        end else if (WE) begin
            for (int i = 0; i < NDIG; i++)
                if (int'(WADDR) == i) codes[i] <= WDATA;
        end
    end

    // The output register samples the phase being loaded, so a restart shows the cursor at once.
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (chg) begin
            cnt_nxt   = '0;
            phase_nxt = 1'b1;
        end else if (in_input) begin
            if (cnt == CW'(BLINK_HALF - 1)) begin
                cnt_nxt   = '0;
                phase_nxt = ~phase;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            phase  <= 1'b1;
            mode_q <= 2'd0;
            cur_q  <= '0;
        end else begin
            cnt    <= cnt_nxt;
            phase  <= phase_nxt;
            mode_q <= MODE;
            cur_q  <= CUR;
        end
    end

`ifdef SEG7_ZERO_BLANK_EN
    always_comb begin
        logic seen;
        seen     = 1'b0;
        zero_sup = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_sup[i] = (mode == MODE_QUESTION) && !seen && (codes[i] == 4'h0);
            seen        = seen || (codes[i] != 4'h0);
        end
    end
`else
    assign zero_sup = '0;
`endif

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic blink_off;
        assign blink_off = in_input && !phase_nxt && (int'(CUR) == i);
        seg7_glyph u_glyph (
            .mode        (mode),
            .code        (codes[i]),
            .blank_force (blink_off || zero_sup[i]),
            .seg         (seg_all[7*i +: 7])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) nHEX <= '1;
        else     nHEX <= seg_all;
    end

endmodule

// File: tb/tb_seg7_multi_disp.sv
// Directed bench for seg7_multi_disp (NDIG=6, BLINK_HALF=4) with hand-derived glyph vectors.
module tb_seg7_multi_disp;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  MODE;
    logic        WE;
    logic [2:0]  WADDR;
    logic [3:0]  WDATA;
    logic        CLR;
    logic [2:0]  CUR;
    logic [41:0] nHEX;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
    localparam logic [6:0] BL = 7'b1111111, DASH = 7'b0111111, RDY = 7'b1111011;
`ifdef SEG7_ZERO_BLANK_EN
    localparam logic [6:0] Z = BL;
`else
    localparam logic [6:0] Z = G0;
`endif

    seg7_multi_disp #(.NDIG(6), .BLINK_HALF(4)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .WE(WE), .WADDR(WADDR),
        .WDATA(WDATA), .CLR(CLR), .CUR(CUR), .nHEX(nHEX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [41:0] p6(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        WE = 1'b1; WADDR = a; WDATA = d;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MODE = 2'd2; WE = 1'b0; WADDR = 3'd0; WDATA = 4'd0; CLR = 1'b0; CUR = 3'd0;
        #2;
        chk("reset_state", nHEX, {42{1'b1}});
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("post_reset_question", nHEX, {42{1'b1}});

        // Write latency: visible on the second edge after WE is seen.
        wr(3'd0, 4'h7);
        chk("write_lat_edge_n", nHEX, {42{1'b1}});
        tick();
        chk("write_lat_edge_n1", nHEX, p6(BL, BL, BL, BL, BL, 7'b1011000));

        for (int i = 0; i < 6; i++) wr(3'(i), 4'(i));
        tick();
        chk("question_012345", nHEX, p6(G5, G4, G3, G2, G1, G0));

        wr(3'd0, 4'd2); wr(3'd1, 4'd4);
        for (int i = 2; i < 6; i++) wr(3'(i), 4'd0);
        tick();
        chk("question_000042", nHEX, p6(Z, Z, Z, Z, G4, G2));

        CLR = 1'b1; WE = 1'b1; WADDR = 3'd3; WDATA = 4'd9;
        tick();
        CLR = 1'b0; WE = 1'b0;
        tick();
        chk("clr_beats_we", nHEX, p6(Z, Z, Z, Z, Z, G0));
        chk("clr_digit3", {35'd0, nHEX[27:21]}, {35'd0, Z});

        wr(3'd7, 4'd8);
        wr(3'd6, 4'd5);
        tick();
        chk("waddr_out_of_range", nHEX, p6(Z, Z, Z, Z, Z, G0));

        // Cursor blink: 4 edges on, 4 edges off, starting on the mode change edge.
        wr(3'd2, 4'h3);
        MODE = 2'd3; CUR = 3'd2;
        for (int k = 0; k < 13; k++) begin
            tick();
            chk($sformatf("blink_cur2_k%0d", k), nHEX,
                p6(DASH, DASH, DASH, ((k / 4) % 2 == 0) ? G5 : BL, DASH, DASH));
        end
        CUR = 3'd1;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk($sformatf("blink_cur1_j%0d", j), nHEX,
                p6(DASH, DASH, DASH, G5, (j < 4) ? DASH : BL, DASH));
        end

        CUR = 3'd7;
        wr(3'd0, 4'h0); wr(3'd1, 4'h5); wr(3'd2, 4'h9); wr(3'd3, 4'hA);
        tick();
        chk("input_glyphs", nHEX, p6(DASH, DASH, BL, G3, G1, DASH));
        repeat (6) tick();
        chk("input_no_blink_cur7", nHEX, p6(DASH, DASH, BL, G3, G1, DASH));

        MODE = 2'd1;
        #1;
        chk("mode_change_latency", nHEX, p6(DASH, DASH, BL, G3, G1, DASH));
        tick();
        chk("ready_mode", nHEX, {6{RDY}});
        MODE = 2'd0;
        tick();
        chk("blank_mode", nHEX, {42{1'b1}});

        MODE = 2'd3; CUR = 3'd0;
        repeat (3) tick();
        chk("pre_async_reset", nHEX, p6(DASH, DASH, BL, G3, G1, DASH));
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset", nHEX, {42{1'b1}});
        tick();
        RST = 1'b0; MODE = 2'd2;
        tick();
        chk("after_reset_codes_f", nHEX, {42{1'b1}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
